data_selector_ctrl: RTL and testbench

- Sequencer for the data selector stage of the sequential router.
- Sweeps the tile memory over an address window: issues single-cycle reads and presents each word's address to the selector one cycle later, aligned with the returned data.
- Repeats sweeps until every row-router address FIFO has drained, then signals done.
- Flags an error if a full sweep produces no hits while any FIFO is still non-empty.

---
 rtl/data_selector_ctrl.sv | 171 +++++++++++++++++
 tb/tb_data_selector_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_selector_ctrl.sv
// Sweep sequencer for the data selector: reads the tile memory over an address window and
// presents each address one cycle later, aligned with the returned data; repeats until the row FIFOs drain.
module data_selector_ctrl #(
   parameter int ADDR_WIDTH      = 6,
   parameter int HEIGHT          = 4,
   parameter int SWEEP_CNT_WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_nrst,
   input  logic                       i_start,
   input  logic                       i_reg_clear,
   input  logic                       i_stall_en,
   input  logic [ADDR_WIDTH-1:0]      i_addr_start,
   input  logic [ADDR_WIDTH-1:0]      i_addr_end,
   input  logic [0:HEIGHT-1]          i_rr_fifo_empty,
   input  logic [0:HEIGHT-1]          i_rr_data_hit,
   output logic                       o_mem_read_en,
   output logic [ADDR_WIDTH-1:0]      o_mem_addr,
   output logic                       o_ds_en,
   output logic                       o_ds_valid_addr,
   output logic [ADDR_WIDTH-1:0]      o_ds_current_addr,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_error,
   output logic [SWEEP_CNT_WIDTH-1:0] o_sweep_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [ADDR_WIDTH-1:0]      r_start;
   logic [ADDR_WIDTH-1:0]      r_end;
   logic                       r_ds_valid;
   logic [ADDR_WIDTH-1:0]      r_ds_addr;
   logic                       r_sweep_hit;
   logic                       r_error;
   logic [SWEEP_CNT_WIDTH-1:0] r_sweep_count;
   logic                       w_read_en;
   logic                       w_ds_en;
   logic [ADDR_WIDTH-1:0]      w_mem_addr;
   logic                       w_any_hit;
   logic                       w_all_empty;

   assign w_any_hit   = |i_rr_data_hit;
   assign w_all_empty = &i_rr_fifo_empty;
   assign w_mem_addr  = (r_state == READ) ? r_addr : '0;

   always_comb begin
      w_next    = r_state;
      w_read_en = 1'b0;
      w_ds_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = (i_addr_start > i_addr_end) ? DONE : READ;
            end
         end
         READ: begin
            w_ds_en   = 1'b1;
            w_read_en = ~i_stall_en;
            if (!i_stall_en && (r_addr == r_end)) begin
               w_next = DRAIN;
            end
         end
         DRAIN: begin
            w_ds_en = 1'b1;
            if (!i_stall_en) begin
               w_next = CHECK;
            end
         end
         CHECK: begin
            if (w_all_empty || !r_sweep_hit) begin
               w_next = DONE;
            end else begin
               w_next = READ;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_start       <= '0;
         r_end         <= '0;
         r_ds_valid    <= 1'b0;
         r_ds_addr     <= '0;
         r_sweep_hit   <= 1'b0;
         r_error       <= 1'b0;
         r_sweep_count <= '0;
      end else if (i_reg_clear) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_start       <= '0;
         r_end         <= '0;
         r_ds_valid    <= 1'b0;
         r_ds_addr     <= '0;
         r_sweep_hit   <= 1'b0;
         r_error       <= 1'b0;
         r_sweep_count <= '0;
      end else begin
         r_state <= w_next;
         // Memory holds its output while stalled, so the presented address holds too.
         if (!i_stall_en) begin
            r_ds_valid <= w_read_en;
            r_ds_addr  <= w_mem_addr;
         end
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_start       <= i_addr_start;
                  r_end         <= i_addr_end;
                  r_addr        <= i_addr_start;
                  r_error       <= 1'b0;
                  r_sweep_count <= '0;
                  r_sweep_hit   <= 1'b0;
               end
            end
            READ: begin
               if (!i_stall_en) begin
                  r_sweep_hit <= r_sweep_hit | w_any_hit;
                  if (r_addr != r_end) begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!i_stall_en) begin
                  r_sweep_hit <= r_sweep_hit | w_any_hit;
               end
            end
            CHECK: begin
               if (!(&r_sweep_count)) begin
                  r_sweep_count <= r_sweep_count + 1'b1;
               end
               if (!w_all_empty) begin
                  if (!r_sweep_hit) begin
                     r_error <= 1'b1;
                  end else begin
                     r_sweep_hit <= 1'b0;
                     r_addr      <= r_start;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_mem_read_en     = w_read_en;
   assign o_mem_addr        = w_mem_addr;
   assign o_ds_en           = w_ds_en;
   assign o_ds_valid_addr   = r_ds_valid;
   assign o_ds_current_addr = r_ds_addr;
   assign o_busy            = (r_state != IDLE);
   assign o_done            = (r_state == DONE);
   assign o_error           = r_error;
   assign o_sweep_count     = r_sweep_count;

endmodule

// File: tb/tb_data_selector_ctrl.sv
// Directed bench for data_selector_ctrl: window sweeps, stall, multi-sweep, no-progress error,
// empty window, synchronous clear and a max-address window.
module tb_data_selector_ctrl;

   localparam int AW = 6;
   localparam int H  = 4;
   localparam int SW = 8;

   logic          i_clk = 1'b0;
   logic          i_nrst;
   logic          i_start;
   logic          i_reg_clear;
   logic          i_stall_en;
   logic [AW-1:0] i_addr_start;
   logic [AW-1:0] i_addr_end;
   logic [0:H-1]  i_rr_fifo_empty;
   logic [0:H-1]  i_rr_data_hit;
   logic          o_mem_read_en;
   logic [AW-1:0] o_mem_addr;
   logic          o_ds_en;
   logic          o_ds_valid_addr;
   logic [AW-1:0] o_ds_current_addr;
   logic          o_busy;
   logic          o_done;
   logic          o_error;
   logic [SW-1:0] o_sweep_count;

   int n_checks = 0;
   int n_errors = 0;

   data_selector_ctrl #(.ADDR_WIDTH(AW), .HEIGHT(H), .SWEEP_CNT_WIDTH(SW)) dut (
      .i_clk            (i_clk),
      .i_nrst           (i_nrst),
      .i_start          (i_start),
      .i_reg_clear      (i_reg_clear),
      .i_stall_en       (i_stall_en),
      .i_addr_start     (i_addr_start),
      .i_addr_end       (i_addr_end),
      .i_rr_fifo_empty  (i_rr_fifo_empty),
      .i_rr_data_hit    (i_rr_data_hit),
      .o_mem_read_en    (o_mem_read_en),
      .o_mem_addr       (o_mem_addr),
      .o_ds_en          (o_ds_en),
      .o_ds_valid_addr  (o_ds_valid_addr),
      .o_ds_current_addr(o_ds_current_addr),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_error          (o_error),
      .o_sweep_count    (o_sweep_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs set afterwards belong to the new cycle.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_window(input logic [AW-1:0] s, input logic [AW-1:0] e);
      i_addr_start = s;
      i_addr_end   = e;
      i_start      = 1'b1;
      cyc();
      i_start = 1'b0;
      #1;
   endtask

   initial begin
      i_nrst = 1'b0; i_start = 1'b0; i_reg_clear = 1'b0; i_stall_en = 1'b0;
      i_addr_start = '0; i_addr_end = '0; i_rr_fifo_empty = '0; i_rr_data_hit = '0;
      #12;
      check("rst_busy", o_busy, 0);
      check("rst_read_en", o_mem_read_en, 0);
      check("rst_ds_valid", o_ds_valid_addr, 0);
      check("rst_ds_addr", o_ds_current_addr, 0);
      check("rst_done", o_done, 0);
      check("rst_count", o_sweep_count, 0);
      i_nrst = 1'b1;
      cyc();

      // Window 0..3, FIFOs empty: single sweep
      i_rr_fifo_empty = 4'b1111;
      start_window(6'd0, 6'd3);
      for (int k = 0; k < 4; k++) begin
         check("t1_read_en", o_mem_read_en, 1);
         check("t1_mem_addr", o_mem_addr, k);
         check("t1_ds_valid", o_ds_valid_addr, (k > 0) ? 1 : 0);
         if (k > 0) check("t1_ds_addr", o_ds_current_addr, k - 1);
         check("t1_ds_en", o_ds_en, 1);
         cyc();
      end
      check("t1_drain_read_en", o_mem_read_en, 0);
      check("t1_drain_ds_valid", o_ds_valid_addr, 1);
      check("t1_drain_ds_addr", o_ds_current_addr, 3);
      cyc();
      check("t1_check_ds_valid", o_ds_valid_addr, 0);
      check("t1_check_done", o_done, 0);
      cyc();
      check("t1_done", o_done, 1);
      check("t1_count", o_sweep_count, 1);
      check("t1_error", o_error, 0);
      cyc();
      check("t1_done_after", o_done, 0);
      check("t1_busy_after", o_busy, 0);

      // Stall for 3 cycles after address 1 is issued
      start_window(6'd0, 6'd3);
      cyc();
      check("t2_addr1", o_mem_addr, 1);
      check("t2_addr1_en", o_mem_read_en, 1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         i_stall_en = 1'b1;
         #1;
         check("t2_stall_read_en", o_mem_read_en, 0);
         check("t2_stall_mem_addr", o_mem_addr, 2);
         check("t2_stall_ds_valid", o_ds_valid_addr, 1);
         check("t2_stall_ds_addr", o_ds_current_addr, 1);
      end
      cyc();
      i_stall_en = 1'b0;
      #1;
      check("t2_rel_read_en", o_mem_read_en, 1);
      check("t2_rel_mem_addr", o_mem_addr, 2);
      check("t2_rel_ds_addr", o_ds_current_addr, 1);
      cyc();
      check("t2_addr3", o_mem_addr, 3);
      check("t2_ds_addr2", o_ds_current_addr, 2);
      cyc();
      check("t2_drain_ds_addr3", o_ds_current_addr, 3);
      cyc();
      cyc();
      check("t2_done", o_done, 1);
      check("t2_count", o_sweep_count, 1);

      // Two sweeps: hit in sweep 1 with FIFOs still full, empty during sweep 2
      cyc();
      i_rr_fifo_empty = 4'b0000;
      start_window(6'd1, 6'd2);
      check("t3_s1_addr", o_mem_addr, 1);
      cyc();
      cyc();
      i_rr_data_hit = 4'b0100;
      #1;
      check("t3_drain_ds_addr", o_ds_current_addr, 2);
      cyc();
      i_rr_data_hit = 4'b0000;
      check("t3_check_busy", o_busy, 1);
      cyc();
      check("t3_s2_read_en", o_mem_read_en, 1);
      check("t3_s2_addr", o_mem_addr, 1);
      check("t3_s2_count", o_sweep_count, 1);
      cyc();
      i_rr_fifo_empty = 4'b1111;
      cyc();
      cyc();
      cyc();
      check("t3_done", o_done, 1);
      check("t3_count", o_sweep_count, 2);
      check("t3_error", o_error, 0);

      // No hits with a FIFO still non-empty
      cyc();
      i_rr_fifo_empty = 4'b0001;
      start_window(6'd0, 6'd1);
      cyc(); cyc(); cyc(); cyc();
      check("t4_done", o_done, 1);
      check("t4_error", o_error, 1);
      check("t4_count", o_sweep_count, 1);
      cyc();
      check("t4_error_sticky", o_error, 1);

      // Empty window start>end
      i_rr_fifo_empty = 4'b1111;
      start_window(6'd5, 6'd2);
      check("t5_done", o_done, 1);
      check("t5_read_en", o_mem_read_en, 0);
      check("t5_error_cleared", o_error, 0);
      check("t5_count", o_sweep_count, 0);
      cyc();
      check("t5_idle", o_busy, 0);

      // Clear in the middle of a read sweep
      i_rr_fifo_empty = 4'b0000;
      start_window(6'd0, 6'd3);
      cyc(); cyc();
      check("t6_addr2", o_mem_addr, 2);
      i_reg_clear = 1'b1;
      cyc();
      i_reg_clear = 1'b0;
      #1;
      check("t6_busy", o_busy, 0);
      check("t6_read_en", o_mem_read_en, 0);
      check("t6_mem_addr", o_mem_addr, 0);
      check("t6_ds_en", o_ds_en, 0);
      check("t6_ds_valid", o_ds_valid_addr, 0);
      check("t6_ds_addr", o_ds_current_addr, 0);
      check("t6_done", o_done, 0);
      cyc();
      check("t6_done_next", o_done, 0);

      // Start and clear together: clear wins
      i_start = 1'b1;
      i_reg_clear = 1'b1;
      cyc();
      i_start = 1'b0;
      i_reg_clear = 1'b0;
      #1;
      check("t7_busy", o_busy, 0);

      // Window ending at the maximum address must not wrap
      i_rr_fifo_empty = 4'b1111;
      start_window(6'd62, 6'd63);
      check("t8_addr62", o_mem_addr, 62);
      cyc();
      check("t8_addr63", o_mem_addr, 63);
      cyc();
      check("t8_drain_read_en", o_mem_read_en, 0);
      check("t8_drain_ds_addr", o_ds_current_addr, 63);
      cyc();
      cyc();
      check("t8_done", o_done, 1);
      check("t8_count", o_sweep_count, 1);
      cyc();
      check("t8_idle_read_en", o_mem_read_en, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
